fft_bitrev_loader: RTL and testbench
====================================

# fft_bitrev_loader

Reorders samples between the AXI bridge's input RAM and the FFT working RAM. The block starts when the bridge reports that all samples are loaded, reads N samples linearly from the source RAM, and writes each one to the destination RAM at its bit-reversed address. It then pulses done so the radix-2 FFT core can run in place on naturally ordered butterflies. Throughput is one sample per clock, and the block handles the source RAM's one-cycle read latency.

## Interface
- DATA_WIDTH, 32, sample width.
- ADDR_WIDTH, 12, RAM address width; also the width of i_SAMPLES_NUMBER.
- i_clk  input  1  single clock; all logic on the rising edge.
- i_rstn  input  1  synchronous active-low reset.
- i_START  input  1  single-cycle start pulse, driven from the bridge's o_DATA_LOADED.
- i_SAMPLES_NUMBER  input  ADDR_WIDTH  sample count N; sampled only on the start edge.
- o_SRC_ADR  output  ADDR_WIDTH  source RAM read address; registered.
- i_SRC_DATA  input  DATA_WIDTH  source RAM read data; valid one cycle after the address.
- o_DST_ADR  output  ADDR_WIDTH  destination RAM write address; registered.
- o_DST_DATA  output  DATA_WIDTH  destination RAM write data; registered.
- o_DST_WRITE  output  1  destination write strobe; one write per cycle while high.
- o_BUSY  output  1  high while the state is CHECK, RUN or DRAIN.
- o_DONE  output  1  one-cycle pulse after the last write.
- o_ERROR  output  1  one-cycle pulse on an invalid N.
- o_STATE  output  3  FSM state: IDLE=0, CHECK=1, RUN=2, DRAIN=3, DONE=4.

## Operation
- Reset: every output is 0, the FSM goes to IDLE, and the counters clear. A reset during RUN or DRAIN aborts the transfer at that edge, and no further writes occur.
- IDLE: when i_START=1, latch N, go to CHECK. i_START is ignored in every other state.
- CHECK: N is valid only if it is a power of two in the range 2..2^(ADDR_WIDTH-1).
  - Valid N: compute B = log2(N), set o_SRC_ADR=0 and go to RUN.
  - Invalid N (0, 1, non-power-of-two, or out of range): pulse o_ERROR, return to IDLE, perform no writes.
- RUN: present o_SRC_ADR = k for k = 0..N-1, one address per cycle.
  - Move to DRAIN after k = N-1 has been presented.
- Pipeline: capture i_SRC_DATA one cycle after the read and present the write on the following cycle.
  - o_DST_ADR = rev_B(k): bits [B-1:0] of k reversed, upper bits 0.
  - o_DST_DATA = source word k.
  - o_DST_WRITE=1 for that cycle.
- DRAIN: lasts 2 cycles, flushing the last two writes. Then go to DONE.
- DONE: o_DONE=1 for one cycle, then return to IDLE.
- Address and data outputs hold their last values when o_DST_WRITE=0. Only o_DST_WRITE qualifies them.
- Counters do not wrap. The read counter stops at N-1, and the state transition is decoded from k == N-1.

## Timing
- T0 is the rising edge that samples i_START=1 in IDLE.
- After T0+1: state RUN, o_SRC_ADR=0, o_BUSY=1. On an invalid N, o_ERROR=1 instead and the state is IDLE.
- After T0+1+k: o_SRC_ADR=k.
- After T0+3+k: o_DST_WRITE=1, o_DST_ADR=rev_B(k).
- First write appears after T0+3. Last write appears after T0+N+2.
- After T0+N+3: o_DONE=1, o_BUSY=0.
- After T0+N+4: state IDLE. A new i_START is accepted at that edge or later.
- Total start-to-done latency is N+3 cycles. N=8 gives done after T0+11.
- i_START asserted together with reset deassertion is ignored; reset wins.

## Configuration
- FFT_BITREV_BYPASS_EN defined: adds input port i_BYPASS (1 bit), sampled at T0.
  - i_BYPASS=1: o_DST_ADR = k, a linear copy with identical timing, validity check and handshake.
  - i_BYPASS=0: normal bit-reversed reordering.
- Macro undefined: the port does not exist and the block always bit-reverses.

## Test plan
- N=8, source MEM[k]=2k, pulse i_START:
  - destination = {0,8,4,12,2,10,6,14};
  - exactly 8 writes;
  - o_DONE after T0+11.
- N=10, then N=0:
  - o_ERROR pulses after T0+1 in both cases;
  - o_DST_WRITE never asserts;
  - o_DONE never asserts;
  - state returns to IDLE.
- N=2048:
  - the write for k=1 goes to address 1024;
  - the write for k=2047 goes to address 2047;
  - 2048 writes total, o_DONE after T0+2051.
- N=16, pulse i_START again at T0+5:
  - the second pulse is ignored;
  - 16 writes total, a single o_DONE pulse.
- N=16, assert i_rstn=0 at T0+8:
  - the next edge gives all outputs 0 and state IDLE;
  - no writes occur after that edge;
  - a restart after release completes normally.
- With FFT_BITREV_BYPASS_EN, i_BYPASS=1, N=8, source MEM[k]=k:
  - destination MEM[k]=k for all k;
  - o_DONE after T0+11.

Source files
------------

// File: rtl/fft_bitrev_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bitrev_loader
//  Description : Copies N samples from the bridge input RAM to the FFT working
//                RAM, writing source word k to destination address rev_B(k)
//                (bits [B-1:0] of k reversed, B = log2(N)). One sample per
//                clock; absorbs the source RAM's one-cycle read latency.
//  Ports       : i_clk, i_rstn (sync, active low)
//                i_START, i_SAMPLES_NUMBER       - start pulse and count N
//                o_SRC_ADR / i_SRC_DATA           - source RAM read port
//                o_DST_ADR / o_DST_DATA / o_DST_WRITE - destination write port
//                o_BUSY, o_DONE, o_ERROR, o_STATE - status
//                i_BYPASS (only with FFT_BITREV_BYPASS_EN) - linear copy
//  Options     : `define FFT_BITREV_BYPASS_EN adds i_BYPASS
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_START,
   input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
`ifdef FFT_BITREV_BYPASS_EN
   input  logic                  i_BYPASS,
`endif
   output logic [ADDR_WIDTH-1:0] o_SRC_ADR,
   input  logic [DATA_WIDTH-1:0] i_SRC_DATA,
   output logic [ADDR_WIDTH-1:0] o_DST_ADR,
   output logic [DATA_WIDTH-1:0] o_DST_DATA,
   output logic                  o_DST_WRITE,
   output logic                  o_BUSY,
   output logic                  o_DONE,
   output logic                  o_ERROR,
   output logic [2:0]            o_STATE
);

   localparam int B_W = $clog2(ADDR_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] n_lat;
   logic [ADDR_WIDTH-1:0] last_k;
   logic                  n_valid;
   logic [B_W-1:0]        log2_n;
   logic [B_W-1:0]        log2_b;
   logic [B_W-1:0]        shamt;
   logic                  drain_cnt;
   logic                  rd_valid;
   logic [ADDR_WIDTH-1:0] rd_k;
   logic [ADDR_WIDTH-1:0] rev_full;
   logic [ADDR_WIDTH-1:0] rev_k;
   logic [ADDR_WIDTH-1:0] dst_adr_next;
`ifdef FFT_BITREV_BYPASS_EN
   logic                  bypass_lat;
`endif

   assign last_k = n_lat - ADDR_WIDTH'(1);

   // Any power of two representable in ADDR_WIDTH bits is at most
   // 2^(ADDR_WIDTH-1), so only the lower bound needs an explicit test.
   always_comb begin
      n_valid = (n_lat >= ADDR_WIDTH'(2)) &&
                ((n_lat & (n_lat - ADDR_WIDTH'(1))) == '0);
      log2_n  = '0;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         if (n_lat[i]) log2_n = B_W'(i);
      end
   end

   // Reverse all ADDR_WIDTH bits, then shift the reversed B-bit field down.
   always_comb begin
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         rev_full[i] = rd_k[ADDR_WIDTH-1-i];
      end
      shamt        = B_W'(ADDR_WIDTH) - log2_b;
      rev_k        = rev_full >> shamt;
      dst_adr_next = rev_k;
`ifdef FFT_BITREV_BYPASS_EN
      if (bypass_lat) dst_adr_next = rd_k;
`endif
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_START) state_next = CHECK;
         CHECK:   state_next = n_valid ? RUN : IDLE;
         RUN:     if (o_SRC_ADR == last_k) state_next = DRAIN;
         DRAIN:   if (drain_cnt) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign o_STATE = state;
   assign o_BUSY  = (state == CHECK) || (state == RUN) || (state == DRAIN);
   assign o_DONE  = (state == DONE);

   // ----------------------------------------------------------- datapath
   // Read pipeline: address k presented in RUN, data arrives a cycle later
   // (rd_valid/rd_k mark it), and it is registered onto the write port.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         n_lat       <= '0;
         log2_b      <= '0;
         drain_cnt   <= 1'b0;
         rd_valid    <= 1'b0;
         rd_k        <= '0;
         o_SRC_ADR   <= '0;
         o_DST_ADR   <= '0;
         o_DST_DATA  <= '0;
         o_DST_WRITE <= 1'b0;
         o_ERROR     <= 1'b0;
`ifdef FFT_BITREV_BYPASS_EN
         bypass_lat  <= 1'b0;
`endif
      end else begin
         o_ERROR     <= 1'b0;
         rd_valid    <= (state == RUN);
         rd_k        <= o_SRC_ADR;
         o_DST_WRITE <= rd_valid;
         if (rd_valid) begin
            o_DST_ADR  <= dst_adr_next;
            o_DST_DATA <= i_SRC_DATA;
         end
         case (state)
            IDLE: begin
               if (i_START) begin
                  n_lat      <= i_SAMPLES_NUMBER;
`ifdef FFT_BITREV_BYPASS_EN
                  bypass_lat <= i_BYPASS;
`endif
               end
            end
            CHECK: begin
               if (n_valid) begin
                  log2_b    <= log2_n;
                  o_SRC_ADR <= '0;
                  drain_cnt <= 1'b0;
               end else begin
                  o_ERROR   <= 1'b1;
               end
            end
            RUN: begin
               // Saturate at N-1; the FSM leaves RUN on that value.
               if (o_SRC_ADR != last_k) o_SRC_ADR <= o_SRC_ADR + ADDR_WIDTH'(1);
            end
            DRAIN: drain_cnt <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_bitrev_loader
//  Description : Self-checking bench for fft_bitrev_loader. Source RAM model
//                with one-cycle read latency, destination RAM capture, and an
//                arithmetic reference for bit-reversed placement and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_loader;
   localparam int DW = 32;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [AW-1:0] n_in;
`ifdef FFT_BITREV_BYPASS_EN
   logic          bypass;
`endif
   logic [AW-1:0] src_adr, dst_adr;
   logic [DW-1:0] src_data, dst_data;
   logic          dst_write, busy, done, error;
   logic [2:0]    state;

   fft_bitrev_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk            (clk),
      .i_rstn           (rstn),
      .i_START          (start),
      .i_SAMPLES_NUMBER (n_in),
`ifdef FFT_BITREV_BYPASS_EN
      .i_BYPASS         (bypass),
`endif
      .o_SRC_ADR        (src_adr),
      .i_SRC_DATA       (src_data),
      .o_DST_ADR        (dst_adr),
      .o_DST_DATA       (dst_data),
      .o_DST_WRITE      (dst_write),
      .o_BUSY           (busy),
      .o_DONE           (done),
      .o_ERROR          (error),
      .o_STATE          (state)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] src_mem [0:4095];
   logic [DW-1:0] dst_mem [0:4095];
   always @(posedge clk) src_data <= src_mem[src_adr];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------- reference model
   function automatic bit model_valid(input int n);
      for (int p = 1; p < AW; p++) if ((1 << p) == n) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_adr(input int k, input int n, input bit byp);
      int b, x, r;
      if (byp) return k;
      b = 0;
      while ((1 << b) < n) b++;
      x = k; r = 0;
      repeat (b) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
   endfunction

   // Observations of the last transfer
   int st_j1, src_j1, busy_j1, busy_done, err_at, done_at, ndone;
   int nwr, bad, final_state, wr_after_rst, dst_mism, tail;
   bit rst_zero, rst_seen;

   // pat: 0 -> 2k, 1 -> k, 2 -> random. restart_at/rst_at: edge index after
   // T0 where an extra start is sampled / reset is sampled (-1 = none).
   task automatic run_xfer(input int n, input bit byp, input int pat,
                           input int restart_at, input int rst_at);
      for (int k = 0; k < 4096; k++) begin
         src_mem[k] = (pat == 0) ? DW'(2 * k) : (pat == 1) ? DW'(k) : $urandom;
         dst_mem[k] = 32'hdeadbeef;
      end
      err_at = -1; done_at = -1; ndone = 0; nwr = 0; bad = 0;
      wr_after_rst = 0; rst_zero = 0; rst_seen = 0;
      st_j1 = -1; src_j1 = -1; busy_j1 = -1; busy_done = -1;
      @(negedge clk);
      start = 1'b1;
      n_in  = AW'(n);
`ifdef FFT_BITREV_BYPASS_EN
      bypass = byp;
`endif
      @(posedge clk);                 // T0
      @(negedge clk);
      start = 1'b0;
      n_in  = AW'($urandom);          // must be ignored after T0
      for (int j = 1; j < n + 40; j++) begin
         @(posedge clk);
         @(negedge clk);              // now after T0+j
         if (j == 1) begin
            st_j1 = state; src_j1 = src_adr; busy_j1 = busy;
         end
         if (error && err_at < 0) err_at = j;
         if (done) begin
            ndone++;
            if (done_at < 0) begin done_at = j; busy_done = busy; end
         end
         if (dst_write) begin
            dst_mem[dst_adr] = dst_data;
            if (rst_seen) wr_after_rst++;
            else begin
               if (nwr >= n || j != 3 + nwr ||
                   int'(dst_adr) != model_adr(nwr, n, byp) ||
                   dst_data != src_mem[nwr]) bad++;
               nwr++;
            end
         end
         if (j == rst_at) begin
            rst_zero = (src_adr == 0) && (dst_adr == 0) && (dst_data == 0) &&
                       !dst_write && !busy && !done && !error && (state == 0);
            rst_seen = 1'b1;
         end
         rstn  = !(j == rst_at - 1 || rst_seen);
         start = (j == restart_at - 1);
         if ((done_at > 0 && j >= done_at + tail) ||
             (err_at > 0 && j >= err_at + 12) ||
             (rst_seen && j >= rst_at + 6)) break;
      end
      final_state = state;
      rstn = 1'b1; start = 1'b0;
      dst_mism = 0;
      for (int k = 0; k < n && k < 4096; k++)
         if (dst_mem[model_adr(k, n, byp)] !== src_mem[k]) dst_mism++;
   endtask

   task automatic check_xfer(input int n);
      bit v;
      v = model_valid(n);
      check($sformatf("n%0d_error_at", n), err_at, v ? -1 : 1);
      check($sformatf("n%0d_writes", n), nwr, v ? n : 0);
      check($sformatf("n%0d_done_at", n), done_at, v ? n + 3 : -1);
      check($sformatf("n%0d_bad_writes", n), bad, 0);
      check($sformatf("n%0d_final_state", n), final_state, 0);
      if (v) begin
         check($sformatf("n%0d_t1_state", n), st_j1, 2);
         check($sformatf("n%0d_t1_src_adr", n), src_j1, 0);
         check($sformatf("n%0d_t1_busy", n), busy_j1, 1);
         check($sformatf("n%0d_busy_at_done", n), busy_done, 0);
         check($sformatf("n%0d_dst_contents", n), dst_mism, 0);
      end
   endtask

   typedef struct {
      int n;
      int pat;
   } vec_t;

   vec_t tbl [0:10];

   initial begin
      tbl[0]  = '{8, 0};    tbl[1]  = '{10, 2};  tbl[2]  = '{0, 2};
      tbl[3]  = '{2, 2};    tbl[4]  = '{2048, 0}; tbl[5] = '{1, 2};
      tbl[6]  = '{4095, 2}; tbl[7]  = '{3, 2};   tbl[8]  = '{16, 2};
      tbl[9]  = '{1024, 2}; tbl[10] = '{4096 - 2048 + 64, 2};
      tail = 1;

      // Reset with start held high: reset wins
      rstn = 1'b0; start = 1'b1; n_in = 12'd8;
`ifdef FFT_BITREV_BYPASS_EN
      bypass = 1'b0;
`endif
      for (int k = 0; k < 4096; k++) src_mem[k] = '0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {src_adr, dst_adr, dst_data, dst_write, busy, done, error}, 0);
      check("rst_state", state, 0);
      rstn = 1'b1; start = 1'b0;
      @(negedge clk);
      check("post_rst_idle", state, 0);

      // Table-driven transfers
      for (int t = 0; t <= 10; t++) begin
         run_xfer(tbl[t].n, 1'b0, tbl[t].pat, -1, -1);
         check_xfer(tbl[t].n);
         if (tbl[t].n == 8) begin
            check("n8_dst1", dst_mem[1], 8);
            check("n8_dst3", dst_mem[3], 12);
            check("n8_dst6", dst_mem[6], 6);
         end
         if (tbl[t].n == 2048) begin
            check("n2048_k1_at_1024", dst_mem[1024], 2);
            check("n2048_k2047_at_2047", dst_mem[2047], 2 * 2047);
         end
      end

      // Randomised counts, valid and invalid
      for (int r = 0; r < 8; r++) begin
         int n;
         n = ($urandom_range(0, 1) == 1) ? (1 << $urandom_range(1, 8))
                                         : int'($urandom_range(0, 300));
         run_xfer(n, 1'b0, 2, -1, -1);
         check_xfer(n);
      end

      // Second start during the transfer is ignored
      tail = 25;
      run_xfer(16, 1'b0, 2, 5, -1);
      tail = 1;
      check("restart_writes", nwr, 16);
      check("restart_bad", bad, 0);
      check("restart_done_at", done_at, 19);
      check("restart_done_pulses", ndone, 1);

      // Reset mid-transfer, then a normal restart
      run_xfer(16, 1'b0, 2, -1, 8);
      check("midrst_zero_outputs", rst_zero, 1);
      check("midrst_writes_before", nwr, 5);
      check("midrst_writes_after", wr_after_rst, 0);
      check("midrst_no_done", done_at, -1);
      run_xfer(16, 1'b0, 2, -1, -1);
      check_xfer(16);

`ifdef FFT_BITREV_BYPASS_EN
      run_xfer(8, 1'b1, 1, -1, -1);
      check("byp_done_at", done_at, 11);
      check("byp_writes", nwr, 8);
      check("byp_bad", bad, 0);
      check("byp_dst_contents", dst_mism, 0);
      bypass = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
